// File: rtl/fifo_wptr_full.sv
// Write-side control of the async FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and the full / almost-full / fill-level / sticky-overflow flags.
module fifo_wptr_full #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);
    localparam int A = ADDRSIZE;

    logic [A:0] wbin_q, wbin_d;
    logic [A:0] wptr_q, wptr_d;
    logic [A:0] wq1_rptr_q, wq1_rptr_d;
    logic [A:0] wq2_rptr_q, wq2_rptr_d;
    logic       wfull_q, wfull_d;
    logic       wafull_q, wafull_d;
    logic [A:0] wlevel_q, wlevel_d;
    logic       woverflow_q, woverflow_d;

    logic       wr_ok;
    logic [A:0] wbinnext, wgraynext, rbin_s;

    always_comb begin
        wr_ok     = winc & ~wfull_q;
        wbinnext  = wbin_q + {{A{1'b0}}, wr_ok};
        wgraynext = (wbinnext >> 1) ^ wbinnext;

        // Gray-to-binary of the synchronised read pointer, MSB down
        rbin_s    = '0;
        rbin_s[A] = wq2_rptr_q[A];
        for (int i = A - 1; i >= 0; i--)
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr_q[i];

        wbin_d      = wbinnext;
        wptr_d      = wgraynext;
        wq1_rptr_d  = rptr;
        wq2_rptr_d  = wq1_rptr_q;
        wfull_d     = (wgraynext == {~wq2_rptr_q[A:A-1], wq2_rptr_q[A-2:0]});
        wlevel_d    = wbinnext - rbin_s;
        wafull_d    = (wlevel_d >= (A+1)'(AFULL_THRESH));
        woverflow_d = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wq1_rptr_q  <= '0;
            wq2_rptr_q  <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wlevel_q    <= '0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wq1_rptr_q  <= wq1_rptr_d;
            wq2_rptr_q  <= wq2_rptr_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            wlevel_q    <= wlevel_d;
            woverflow_q <= woverflow_d;
        end
    end

    assign waddr     = wbin_q[A-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wlevel    = wlevel_q;
    assign woverflow = woverflow_q;
endmodule
